gb_cpu_sequencer: RTL and testbench

//  M-cycle sequencer that drives gb_cpu_decoder and steps its schedule.
//  - Accepts opcode bytes from fetch; tracks the 0xCB-prefix state, IME and the EI delay.
//  - Enters HALT, arbitrates NUM_IRQ interrupt lines by priority and runs the ISR schedule.
//  - Outputs the current T/M-cycle index that the datapath uses to select schedule entries.

---
 rtl/gb_cpu_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_gb_cpu_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_sequencer.sv
// gb_cpu_sequencer: M-cycle sequencer for the Game Boy CPU core.
// Steps the decoder schedule one M-cycle at a time, handles the 0xCB prefix,
// IME with its one-instruction EI delay, HALT, and interrupt dispatch.
// Pulse outputs (instr_done, irq_ack) are registered one T-cycle ahead so they
// are high exactly during the m_tick clock; this needs TCYCLES_PER_M >= 2.
module gb_cpu_sequencer #(
    parameter int TCYCLES_PER_M = 4,
    parameter int MCYCLE_W      = 3,
    parameter int NUM_IRQ       = 5,
    parameter int ISR_LEN       = 5,
    parameter int ISR_ACK_STEP  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ir_valid,
    input  logic [7:0]                            ir_opcode,
    output logic                                  ir_ready,
    input  logic [MCYCLE_W-1:0]                   sched_len,
    input  logic                                  sched_cb,
    input  logic                                  sched_halt,
    input  logic                                  sched_ei,
    input  logic                                  sched_di,
    input  logic [NUM_IRQ-1:0]                    irq_req,
    output logic [NUM_IRQ-1:0]                    irq_ack,
    output logic [7:0]                            opcode,
    output logic                                  cb_prefix,
    output logic                                  isr_cmd,
    output logic [MCYCLE_W-1:0]                   mcycle,
    output logic [$clog2(TCYCLES_PER_M)-1:0]      tcycle,
    output logic                                  ime,
    output logic                                  halted,
    output logic                                  instr_done
);

    localparam int TC_W = $clog2(TCYCLES_PER_M);

    localparam logic [TC_W-1:0]     TC_ZERO  = {TC_W{1'b0}};
    localparam logic [TC_W-1:0]     TC_ONE   = {{(TC_W-1){1'b0}}, 1'b1};
    localparam logic [TC_W-1:0]     TC_LAST  = TC_W'(TCYCLES_PER_M - 1);
    localparam logic [TC_W-1:0]     TC_PRE   = TC_W'(TCYCLES_PER_M - 2);
    localparam logic [MCYCLE_W-1:0] MC_ZERO  = {MCYCLE_W{1'b0}};
    localparam logic [MCYCLE_W-1:0] MC_ONE   = {{(MCYCLE_W-1){1'b0}}, 1'b1};
    localparam logic [MCYCLE_W-1:0] ISR_LAST = MCYCLE_W'(ISR_LEN - 1);
    localparam logic [MCYCLE_W-1:0] ACK_STEP = MCYCLE_W'(ISR_ACK_STEP);
    localparam logic [NUM_IRQ-1:0]  IRQ_ZERO = {NUM_IRQ{1'b0}};
    localparam logic [NUM_IRQ-1:0]  IRQ_ONE  = {{(NUM_IRQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_ISR   = 2'd3
    } state_t;

    state_t               state_r;
    logic [NUM_IRQ-1:0]   irq_sel_r;
    logic                 ei_pend_r;

    logic                 m_tick_s;
    logic                 pre_tick_s;
    logic [MCYCLE_W-1:0]  len_m1_s;
    logic                 last_step_s;
    logic                 exec_last_s;
    logic                 isr_last_s;
    logic                 irq_any_s;
    logic                 take_irq_s;

    // Lowest set request bit as a one-hot vector: index 0 wins.
    function automatic logic [NUM_IRQ-1:0] lowest_onehot(input logic [NUM_IRQ-1:0] req);
        return req & (~req + IRQ_ONE);
    endfunction

    assign m_tick_s    = (tcycle == TC_LAST);
    assign pre_tick_s  = (tcycle == TC_PRE);
    assign last_step_s = (mcycle == len_m1_s);
    assign exec_last_s = (state_r == ST_EXEC) && last_step_s;
    assign isr_last_s  = (state_r == ST_ISR) && (mcycle == ISR_LAST);
    assign irq_any_s   = |irq_req;
    assign take_irq_s  = ime && irq_any_s && !sched_cb;

    // Final step index of the decoded schedule; a zero length runs as one M-cycle.
    always_comb begin
        len_m1_s = MC_ZERO;
        if (sched_len == MC_ZERO) begin
            len_m1_s = MC_ZERO;
        end else begin
            len_m1_s = sched_len - MC_ONE;
        end
    end

    // Opcode handshake: open in FETCH and in the last EXEC step when the next step is a fetch.
    always_comb begin
        ir_ready = 1'b0;
        if (!rst_n) begin
            ir_ready = 1'b0;
        end else if (state_r == ST_FETCH) begin
            ir_ready = 1'b1;
        end else begin
            ir_ready = exec_last_s && !sched_halt && !take_irq_s;
        end
    end

    // Sequencer state, T/M counters, IME/prefix tracking and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            irq_sel_r  <= IRQ_ZERO;
            ei_pend_r  <= 1'b0;
            tcycle     <= TC_ZERO;
            mcycle     <= MC_ZERO;
            opcode     <= 8'h00;
            cb_prefix  <= 1'b0;
            isr_cmd    <= 1'b0;
            ime        <= 1'b0;
            halted     <= 1'b0;
            instr_done <= 1'b0;
            irq_ack    <= IRQ_ZERO;
        end else begin
            instr_done <= 1'b0;
            irq_ack    <= IRQ_ZERO;
            tcycle     <= m_tick_s ? TC_ZERO : (tcycle + TC_ONE);

            // Pulses are armed one T-cycle early so they coincide with the m_tick clock.
            if (pre_tick_s) begin
                instr_done <= exec_last_s || isr_last_s;
                if ((state_r == ST_ISR) && (mcycle == ACK_STEP)) begin
                    irq_ack <= irq_sel_r;
                end
            end

            if (m_tick_s) begin
                case (state_r)
                    ST_FETCH: begin
                        if (ir_valid) begin
                            opcode  <= ir_opcode;
                            mcycle  <= MC_ZERO;
                            state_r <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (!last_step_s) begin
                            mcycle <= mcycle + MC_ONE;
                        end else begin
                            mcycle    <= MC_ZERO;
                            cb_prefix <= sched_cb;
                            if (sched_di) begin
                                ime       <= 1'b0;
                                ei_pend_r <= 1'b0;
                            end else if (sched_ei) begin
                                ei_pend_r <= 1'b1;
                            end else if (ei_pend_r) begin
                                ime       <= 1'b1;
                                ei_pend_r <= 1'b0;
                            end
                            if (sched_halt) begin
                                halted  <= 1'b1;
                                state_r <= ST_HALT;
                            end else if (take_irq_s) begin
                                irq_sel_r <= lowest_onehot(irq_req);
                                ime       <= 1'b0;
                                isr_cmd   <= 1'b1;
                                state_r   <= ST_ISR;
                            end else if (ir_valid) begin
                                opcode  <= ir_opcode;
                                state_r <= ST_EXEC;
                            end else begin
                                state_r <= ST_FETCH;
                            end
                        end
                    end
                    ST_HALT: begin
                        // Any pending request wakes the core; IME only decides whether to dispatch.
                        if (irq_any_s) begin
                            halted <= 1'b0;
                            mcycle <= MC_ZERO;
                            if (ime) begin
                                irq_sel_r <= lowest_onehot(irq_req);
                                ime       <= 1'b0;
                                isr_cmd   <= 1'b1;
                                state_r   <= ST_ISR;
                            end else begin
                                state_r <= ST_FETCH;
                            end
                        end
                    end
                    ST_ISR: begin
                        if (mcycle == ISR_LAST) begin
                            mcycle  <= MC_ZERO;
                            isr_cmd <= 1'b0;
                            state_r <= ST_FETCH;
                        end else begin
                            mcycle <= mcycle + MC_ONE;
                        end
                    end
                    default: begin
                        state_r <= ST_FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Directed bench for gb_cpu_sequencer. A small decoder stand-in feeds the
// schedule inputs from the latched opcode; all checks sample at the m_tick
// clock (tcycle == 3) where the one-clock pulses are visible.
module tb_gb_cpu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ir_valid;
    logic [7:0] ir_opcode;
    logic       ir_ready;
    logic [2:0] sched_len;
    logic       sched_cb;
    logic       sched_halt;
    logic       sched_ei;
    logic       sched_di;
    logic [4:0] irq_req;
    logic [4:0] irq_ack;
    logic [7:0] opcode;
    logic       cb_prefix;
    logic       isr_cmd;
    logic [2:0] mcycle;
    logic [1:0] tcycle;
    logic       ime;
    logic       halted;
    logic       instr_done;

    int checks   = 0;
    int failures = 0;
    logic ack_seen;

    gb_cpu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_valid   (ir_valid),
        .ir_opcode  (ir_opcode),
        .ir_ready   (ir_ready),
        .sched_len  (sched_len),
        .sched_cb   (sched_cb),
        .sched_halt (sched_halt),
        .sched_ei   (sched_ei),
        .sched_di   (sched_di),
        .irq_req    (irq_req),
        .irq_ack    (irq_ack),
        .opcode     (opcode),
        .cb_prefix  (cb_prefix),
        .isr_cmd    (isr_cmd),
        .mcycle     (mcycle),
        .tcycle     (tcycle),
        .ime        (ime),
        .halted     (halted),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder stand-in: 0x01 len 3, 0x10 len 0, 0xCB prefix, 0x76 HALT, 0xFB EI, 0xF3 DI, CB suffix len 2.
    always_comb begin
        sched_len  = 3'd1;
        sched_cb   = 1'b0;
        sched_halt = 1'b0;
        sched_ei   = 1'b0;
        sched_di   = 1'b0;
        if (cb_prefix) begin
            sched_len = 3'd2;
        end else begin
            case (opcode)
                8'h01:   sched_len  = 3'd3;
                8'h10:   sched_len  = 3'd0;
                8'hCB:   sched_cb   = 1'b1;
                8'h76:   sched_halt = 1'b1;
                8'hFB:   sched_ei   = 1'b1;
                8'hF3:   sched_di   = 1'b1;
                default: sched_len  = 3'd1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the m_tick clock of the next M-cycle.
    task automatic next_m();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // From a post-release tcycle==0 point, move to the m_tick clock of that M-cycle.
    task automatic align();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_opcode"},     {24'd0, opcode},     32'd0);
        chk({tag, "_cb_prefix"},  {31'd0, cb_prefix},  32'd0);
        chk({tag, "_isr_cmd"},    {31'd0, isr_cmd},    32'd0);
        chk({tag, "_mcycle"},     {29'd0, mcycle},     32'd0);
        chk({tag, "_tcycle"},     {30'd0, tcycle},     32'd0);
        chk({tag, "_ime"},        {31'd0, ime},        32'd0);
        chk({tag, "_halted"},     {31'd0, halted},     32'd0);
        chk({tag, "_irq_ack"},    {27'd0, irq_ack},    32'd0);
        chk({tag, "_instr_done"}, {31'd0, instr_done}, 32'd0);
        chk({tag, "_ir_ready"},   {31'd0, ir_ready},   32'd0);
    endtask

    // From FETCH: run EI then one NOP; IME becomes 1 at the end of that NOP.
    task automatic enable_ime();
        ir_valid  = 1'b1;
        ir_opcode = 8'hFB;
        next_m();
        ir_opcode = 8'h00;
        next_m();
    endtask

    initial begin
        rst_n     = 1'b0;
        ir_valid  = 1'b0;
        ir_opcode = 8'h00;
        irq_req   = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        align();

        // Overlap: NOP then a 3-cycle op with ir_valid held high.
        chk("m0_tcycle", {30'd0, tcycle}, 32'd3);
        chk("m0_fetch_ready", {31'd0, ir_ready}, 32'd1);
        ir_valid  = 1'b1;
        ir_opcode = 8'h00;
        next_m();
        chk("ovl_m1_opcode", {24'd0, opcode}, 32'h00);
        chk("ovl_m1_mcycle", {29'd0, mcycle}, 32'd0);
        chk("ovl_m1_done", {31'd0, instr_done}, 32'd1);
        chk("ovl_m1_ready", {31'd0, ir_ready}, 32'd1);
        ir_opcode = 8'h01;
        next_m();
        chk("ovl_m2_opcode", {24'd0, opcode}, 32'h01);
        chk("ovl_m2_mcycle", {29'd0, mcycle}, 32'd0);
        chk("ovl_m2_done", {31'd0, instr_done}, 32'd0);
        next_m();
        chk("ovl_m3_mcycle", {29'd0, mcycle}, 32'd1);
        chk("ovl_m3_ready", {31'd0, ir_ready}, 32'd0);
        next_m();
        chk("ovl_m4_mcycle", {29'd0, mcycle}, 32'd2);
        chk("ovl_m4_done", {31'd0, instr_done}, 32'd1);
        ir_valid = 1'b0;
        next_m();
        chk("fetch_stall_ready", {31'd0, ir_ready}, 32'd1);
        chk("fetch_stall_done", {31'd0, instr_done}, 32'd0);

        // Zero-length schedule behaves as one M-cycle.
        ir_valid  = 1'b1;
        ir_opcode = 8'h10;
        next_m();
        chk("len0_done", {31'd0, instr_done}, 32'd1);

        // EI delay with irq 0 held.
        ir_opcode = 8'hFB;
        irq_req   = 5'b00001;
        next_m();
        chk("ei_exec_ime", {31'd0, ime}, 32'd0);
        ir_opcode = 8'h00;
        next_m();
        chk("ei_nop1_ime", {31'd0, ime}, 32'd0);
        chk("ei_nop1_ready", {31'd0, ir_ready}, 32'd1);
        next_m();
        chk("ei_nop2_ime", {31'd0, ime}, 32'd1);
        chk("ei_nop2_isr", {31'd0, isr_cmd}, 32'd0);
        chk("ei_nop2_ready", {31'd0, ir_ready}, 32'd0);
        ir_valid = 1'b0;
        next_m();
        chk("ei_isr0_cmd", {31'd0, isr_cmd}, 32'd1);
        chk("ei_isr0_ime", {31'd0, ime}, 32'd0);
        chk("ei_isr0_mcycle", {29'd0, mcycle}, 32'd0);
        next_m();
        chk("ei_isr1_ack", {27'd0, irq_ack}, 32'd0);
        next_m();
        chk("ei_isr2_ack", {27'd0, irq_ack}, 32'b00001);
        next_m();
        chk("ei_isr3_ack", {27'd0, irq_ack}, 32'd0);
        next_m();
        chk("ei_isr4_done", {31'd0, instr_done}, 32'd1);
        irq_req = 5'b00000;
        next_m();
        chk("ei_post_isr_cmd", {31'd0, isr_cmd}, 32'd0);
        chk("ei_post_ready", {31'd0, ir_ready}, 32'd1);

        // CB prefix blocks the interrupt until the suffix completes.
        enable_ime();
        ir_opcode = 8'hCB;
        irq_req   = 5'b00100;
        next_m();
        chk("cb_exec_ime", {31'd0, ime}, 32'd1);
        chk("cb_exec_ready", {31'd0, ir_ready}, 32'd1);
        chk("cb_exec_prefix", {31'd0, cb_prefix}, 32'd0);
        ir_opcode = 8'h07;
        next_m();
        chk("cb_sfx_prefix", {31'd0, cb_prefix}, 32'd1);
        chk("cb_sfx_opcode", {24'd0, opcode}, 32'h07);
        chk("cb_sfx_isr", {31'd0, isr_cmd}, 32'd0);
        ir_valid = 1'b0;
        next_m();
        chk("cb_sfx_m1", {29'd0, mcycle}, 32'd1);
        chk("cb_sfx_done", {31'd0, instr_done}, 32'd1);
        chk("cb_sfx_ready", {31'd0, ir_ready}, 32'd0);
        next_m();
        chk("cb_isr_cmd", {31'd0, isr_cmd}, 32'd1);
        chk("cb_isr_prefix", {31'd0, cb_prefix}, 32'd0);
        next_m();
        next_m();
        chk("cb_isr_ack", {27'd0, irq_ack}, 32'b00100);
        next_m();
        next_m();
        irq_req = 5'b00000;
        next_m();

        // EI immediately followed by DI leaves IME clear.
        ir_valid  = 1'b1;
        ir_opcode = 8'hFB;
        next_m();
        ir_opcode = 8'hF3;
        next_m();
        ir_opcode = 8'h00;
        next_m();
        chk("eidi_nop_ime", {31'd0, ime}, 32'd0);
        ir_valid = 1'b0;
        next_m();
        chk("eidi_fetch_ime", {31'd0, ime}, 32'd0);

        // HALT with IME clear: wake to FETCH without dispatch.
        ir_valid  = 1'b1;
        ir_opcode = 8'h76;
        next_m();
        chk("halt0_exec_done", {31'd0, instr_done}, 32'd1);
        chk("halt0_exec_ready", {31'd0, ir_ready}, 32'd0);
        ir_valid = 1'b0;
        next_m();
        chk("halt0_halted", {31'd0, halted}, 32'd1);
        next_m();
        chk("halt0_stall", {31'd0, halted}, 32'd1);
        chk("halt0_ready", {31'd0, ir_ready}, 32'd0);
        irq_req = 5'b10000;
        next_m();
        chk("halt0_wake_halted", {31'd0, halted}, 32'd0);
        chk("halt0_wake_isr", {31'd0, isr_cmd}, 32'd0);
        chk("halt0_wake_ready", {31'd0, ir_ready}, 32'd1);
        chk("halt0_wake_ack", {27'd0, irq_ack}, 32'd0);
        irq_req = 5'b00000;

        // HALT with IME set: wake straight into the ISR.
        enable_ime();
        ir_opcode = 8'h76;
        next_m();
        ir_valid = 1'b0;
        next_m();
        chk("halt1_halted", {31'd0, halted}, 32'd1);
        irq_req = 5'b10000;
        next_m();
        chk("halt1_isr", {31'd0, isr_cmd}, 32'd1);
        chk("halt1_ime", {31'd0, ime}, 32'd0);
        chk("halt1_halted_off", {31'd0, halted}, 32'd0);
        next_m();
        next_m();
        chk("halt1_ack", {27'd0, irq_ack}, 32'b10000);
        next_m();
        next_m();
        chk("halt1_done", {31'd0, instr_done}, 32'd1);
        irq_req = 5'b00000;
        next_m();

        // Priority: lowest index wins; mid-ISR change does not move the ack.
        enable_ime();
        irq_req = 5'b10110;
        next_m();
        chk("prio_ready", {31'd0, ir_ready}, 32'd0);
        ir_valid = 1'b0;
        next_m();
        irq_req = 5'b00001;
        next_m();
        next_m();
        chk("prio_ack", {27'd0, irq_ack}, 32'b00010);
        next_m();
        next_m();
        irq_req = 5'b00000;
        next_m();

        // Reset during ISR step 1: everything clears, no ack appears.
        enable_ime();
        irq_req = 5'b01000;
        next_m();
        ir_valid = 1'b0;
        next_m();
        next_m();
        chk("rst_isr_step", {29'd0, mcycle}, 32'd1);
        chk("rst_isr_cmd", {31'd0, isr_cmd}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        ack_seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (irq_ack != 5'b00000) ack_seen = 1'b1;
        end
        chk("rst_no_ack", {31'd0, ack_seen}, 32'd0);
        irq_req = 5'b00000;
        rst_n   = 1'b1;
        align();
        chk("rst_post_ready", {31'd0, ir_ready}, 32'd1);
        chk("rst_post_isr", {31'd0, isr_cmd}, 32'd0);
        chk("rst_post_tcycle", {30'd0, tcycle}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
